sipo_frame_ctrl: RTL
====================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, word length in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: serial_in  input  1  serial data bit.
REQ-005 SHALL have port: bit_valid  input  1  qualifies serial_in for the current cycle.
REQ-006 SHALL have port: frame_start  input  1  marks the first bit of a frame; meaningful only with bit_valid=1.
REQ-007 SHALL have port: out_data  output  WIDTH  assembled parallel word.
REQ-008 SHALL have port: out_valid  output  1  out_data holds an unconsumed word.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the word when out_valid=1.
REQ-010 SHALL have port: busy  output  1  high while in SHIFT state.
REQ-011 SHALL have port: bit_count  output  $clog2(WIDTH+1)  bits accepted in the current frame.
REQ-012 SHALL have port: overflow  output  1  sticky; a completed word was dropped.
REQ-013 SHALL have port: resync_err  output  1  one-cycle pulse; frame restarted before completion.
REQ-014 SHALL have port: clear_ovf  input  1  synchronous clear of overflow.

Function
REQ-015 SHALL implement FSM with states IDLE and SHIFT; busy = (state==SHIFT).
REQ-016 Accepted bit (bit_valid=1) SHALL shift into shift-register bit WIDTH-1, existing contents shifting right by one; after WIDTH bits the first bit sits at bit 0.
REQ-017 IDLE: bit_valid=1 with frame_start=1 -> accept bit, bit_count=1, go SHIFT; bit_valid=1 with frame_start=0 -> bit ignored, stay IDLE.
REQ-018 SHIFT: bit_valid=1 with frame_start=0 -> accept bit, bit_count increments.
REQ-019 SHIFT: bit_valid=1 with frame_start=1 -> discard partial word, accept bit as first bit, bit_count=1, resync_err=1 on the following cycle only.
REQ-020 SHIFT: bit_valid=0 -> shift register and bit_count hold.
REQ-021 Word completion: the edge accepting bit number WIDTH SHALL load the completed word into out_data, clear bit_count to 0 and return to IDLE; out_valid=1 from the next cycle (latency 1 cycle after last bit).
REQ-022 out_data SHALL be a separate register; shifting of the next frame continues while out_valid=1.
REQ-023 out_valid and out_data SHALL stay stable until an edge with out_valid=1 and out_ready=1; that edge clears out_valid unless REQ-024 applies.
REQ-024 Completion on the same edge as a handshake SHALL load the new word and keep out_valid=1; overflow unchanged.
REQ-025 Completion with out_valid=1 and out_ready=0 SHALL drop the new word, keep the old out_data, set overflow=1.
REQ-026 overflow SHALL clear on an edge with clear_ovf=1; simultaneous set condition wins (overflow stays 1).
REQ-027 out_ready with out_valid=0 SHALL have no effect.

Reset
REQ-028 reset=1 SHALL asynchronously force state=IDLE, shift register=0, bit_count=0, out_data=0, out_valid=0, overflow=0, resync_err=0, busy=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial word; the first frame after deassertion requires frame_start.
REQ-030 Reset SHALL discard any pending out_valid word without handshake.

Verification (WIDTH=8)
REQ-031 Bits 1,0,1,0,0,1,0,1 on consecutive cycles, frame_start on first, out_ready=1 -> out_data=0xA5, out_valid=1 for exactly one cycle, one cycle after the 8th bit edge.
REQ-032 Same frame with bit_valid=0 gaps of 3 cycles between bits -> out_data=0xA5; busy=1 throughout; bit_count holds during gaps.
REQ-033 Frame 0xA5 then frame 0x3C with out_ready=0 -> out_data stays 0xA5, overflow=1; clear_ovf pulse -> overflow=0; out_ready=1 -> out_valid=0.
REQ-034 4 bits sent, then frame_start with 8 bits of 0xFF -> resync_err pulse 1 cycle, out_data=0xFF.
REQ-035 Reset asserted asynchronously after 5 bits (mid-cycle) -> all outputs 0 immediately; 8 bits without frame_start afterwards -> out_valid stays 0.
REQ-036 Back-to-back frames 0x01,0x80 with out_ready high on completion edge of 0x80 -> out_valid stays 1, out_data=0x80, overflow=0.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - serial-in parallel-out framer with output holding register
// Frames start on frame_start, complete after WIDTH accepted bits, and hand off through a valid/ready word slot.
module sipo_frame_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         serial_in,
   input  logic                         bit_valid,
   input  logic                         frame_start,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count,
   output logic                         overflow,
   output logic                         resync_err,
   input  logic                         clear_ovf
);

   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] first_word;
   logic             restart;
   logic             resync;
   logic             accept;
   logic             complete;
   logic             store;
   logic             drop;

   // A frame_start bit always begins a fresh word, whether from IDLE or mid-frame.
   assign restart    = bit_valid & frame_start;
   assign resync     = restart & (state == SHIFT);
   assign accept     = bit_valid & ~frame_start & (state == SHIFT);
   assign complete   = accept & (bit_count == CW'(WIDTH-1));
   assign shifted    = {serial_in, shift_reg[WIDTH-1:1]};
   assign first_word = {serial_in, {(WIDTH-1){1'b0}}};
   assign store      = complete & (~out_valid | out_ready);
   assign drop       = complete & out_valid & ~out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (restart) state_nxt = SHIFT;
         SHIFT:   if (complete) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg  <= '0;
         bit_count  <= '0;
         resync_err <= 1'b0;
      end else begin
         resync_err <= resync;
         if (restart) begin
            shift_reg <= first_word;
            bit_count <= CW'(1);
         end else if (complete) begin
            shift_reg <= shifted;
            bit_count <= '0;
         end else if (accept) begin
            shift_reg <= shifted;
            bit_count <= bit_count + CW'(1);
         end
      end
   end

   // A completion that meets a handshake refills the slot; one that meets a stalled slot is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (store) begin
            out_data  <= shifted;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule
